// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants (640x480@60 defaults) and elaboration-time helpers.
package vga_timing_pkg;

  localparam int unsigned VGA_H_DISP = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_PW   = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_V_DISP = 480;
  localparam int unsigned VGA_V_FP   = 10;
  localparam int unsigned VGA_V_PW   = 2;
  localparam int unsigned VGA_V_BP   = 33;

  function automatic int unsigned h_total(input int unsigned disp, input int unsigned fp,
                                          input int unsigned pw, input int unsigned bp);
    return disp + fp + pw + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned disp, input int unsigned fp,
                                          input int unsigned pw, input int unsigned bp);
    return disp + fp + pw + bp;
  endfunction

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/raster_axis_cnt.sv
// One raster axis: wrapping position counter with display/sync/last decode.
module raster_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int unsigned DISP = VGA_H_DISP,
  parameter int unsigned FP   = VGA_H_FP,
  parameter int unsigned PW   = VGA_H_PW,
  parameter int unsigned BP   = VGA_H_BP,
  parameter int unsigned W    = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic         wrap,
  output logic [W-1:0] cnt_o,
  output logic         sync_c,
  output logic         disp_c,
  output logic         last_c
);

  localparam int unsigned TOTAL = h_total(DISP, FP, PW, BP);

  logic [W-1:0] cnt_q, cnt_d;

  assign last_c = (cnt_q == W'(TOTAL - 1));
  assign disp_c = (cnt_q < W'(DISP));
  assign sync_c = (cnt_q >= W'(DISP + FP)) && (cnt_q < W'(DISP + FP + PW));
  assign wrap   = en & last_c;
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = last_c ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator; outputs are the registered decode of the
// pre-increment counters, so they trail the counters by one pixel tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISP = VGA_H_DISP,
  parameter int unsigned H_FP   = VGA_H_FP,
  parameter int unsigned H_PW   = VGA_H_PW,
  parameter int unsigned H_BP   = VGA_H_BP,
  parameter int unsigned V_DISP = VGA_V_DISP,
  parameter int unsigned V_FP   = VGA_V_FP,
  parameter int unsigned V_PW   = VGA_V_PW,
  parameter int unsigned V_BP   = VGA_V_BP,
  parameter bit          H_POL  = 1'b0,
  parameter bit          V_POL  = 1'b0,
  parameter int unsigned X_W    = clog2(h_total(H_DISP, H_FP, H_PW, H_BP)),
  parameter int unsigned Y_W    = clog2(v_total(V_DISP, V_FP, V_PW, V_BP))
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_en,
  output logic           hsync,
  output logic           vsync,
  output logic           active,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           line_start,
  output logic           frame_start
);

  localparam int unsigned H_TOTAL = h_total(H_DISP, H_FP, H_PW, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_DISP, V_FP, V_PW, V_BP);

  if (H_DISP == 0 || H_FP == 0 || H_PW == 0 || H_BP == 0 ||
      V_DISP == 0 || V_FP == 0 || V_PW == 0 || V_BP == 0) begin : g_zero_param
    $error("vga_timing_gen: display/porch/pulse parameters must be non-zero");
  end
  if ((64'(1) << X_W) < 64'(H_TOTAL) || (64'(1) << Y_W) < 64'(V_TOTAL)) begin : g_narrow_cnt
    $error("vga_timing_gen: X_W/Y_W too narrow for the raster totals");
  end

  logic           h_wrap, h_sync, h_disp, h_last;
  logic           v_wrap, v_sync, v_disp, v_last;
  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;

  raster_axis_cnt #(
    .DISP(H_DISP), .FP(H_FP), .PW(H_PW), .BP(H_BP), .W(X_W)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .en(pix_en), .wrap(h_wrap),
    .cnt_o(h_cnt), .sync_c(h_sync), .disp_c(h_disp), .last_c(h_last)
  );

  // The vertical axis steps on the horizontal wrap, so vsync only moves at line boundaries.
  raster_axis_cnt #(
    .DISP(V_DISP), .FP(V_FP), .PW(V_PW), .BP(V_BP), .W(Y_W)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .en(h_wrap), .wrap(v_wrap),
    .cnt_o(v_cnt), .sync_c(v_sync), .disp_c(v_disp), .last_c(v_last)
  );

  logic unused_flags;
  assign unused_flags = &{1'b0, h_last, v_wrap, v_last};

  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           active_q, active_d;
  logic [X_W-1:0] pix_x_q, pix_x_d;
  logic [Y_W-1:0] pix_y_q, pix_y_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;

  // Strobes default low so they last exactly one clk regardless of pix_en duty.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      hsync_d       = h_sync ? H_POL : ~H_POL;
      vsync_d       = v_sync ? V_POL : ~V_POL;
      active_d      = h_disp & v_disp;
      pix_x_d       = (h_disp & v_disp) ? h_cnt : '0;
      pix_y_d       = (h_disp & v_disp) ? v_cnt : '0;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      active_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance and a tiny 8x6 active-high instance share clk/rst_n/pix_en.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;

  always #5 clk = ~clk;

  logic       d_hs, d_vs, d_act, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_act, s_ls, s_fs;
  logic [2:0] s_x, s_y;

  vga_timing_gen u_dut_def (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(d_hs), .vsync(d_vs), .active(d_act), .pix_x(d_x), .pix_y(d_y),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_DISP(4), .H_FP(1), .H_PW(2), .H_BP(1),
    .V_DISP(3), .V_FP(1), .V_PW(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .X_W(3), .Y_W(3)
  ) u_dut_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(s_hs), .vsync(s_vs), .active(s_act), .pix_x(s_x), .pix_y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    logic en;
    obs_t exp;
  } vec_t;

  obs_t d_obs, s_obs;
  assign d_obs = {d_hs, d_vs, d_act, d_x, d_y, d_ls, d_fs};
  assign s_obs = {s_hs, s_vs, s_act, 7'd0, s_x, 7'd0, s_y, s_ls, s_fs};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic obs_t mk(input logic hs, input logic vs, input logic act,
                              input int x, input int y, input logic ls, input logic fs);
    obs_t o;
    o.hs = hs; o.vs = vs; o.act = act;
    o.x = 10'(x); o.y = 10'(y);
    o.ls = ls; o.fs = fs;
    return o;
  endfunction

  // Reference decode for the 8x6 raster with active-high syncs.
  function automatic obs_t small_ref(input int h, input int v);
    logic a;
    a = (h < 4) && (v < 3);
    return mk((h == 5) || (h == 6), v == 4, a, a ? h : 0, a ? v : 0, h == 0, (h == 0) && (v == 0));
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got hs=%0b vs=%0b act=%0b x=%0d y=%0d ls=%0b fs=%0b, expected hs=%0b vs=%0b act=%0b x=%0d y=%0d ls=%0b fs=%0b",
               name, got.hs, got.vs, got.act, got.x, got.y, got.ls, got.fs,
               exp.hs, exp.vs, exp.act, exp.x, exp.y, exp.ls, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  int   act_cnt, xerr, hs_low, hs_first, ls_cnt, fs_cnt, vs_low, ls_prev_p, ls_period;
  int   mh, mv, fs_seen, fs_t0, fs_per, win_vs, win_act, win_hs;
  int   hold_err, width_err, per_err, per_first, ls_last_c, hs_run, hs_run_first;
  logic hs_seen_high;
  obs_t prev;

  initial begin
    vecs[0]  = '{1'b1, mk(0, 0, 1, 0, 0, 1, 1)};
    vecs[1]  = '{1'b1, mk(0, 0, 1, 1, 0, 0, 0)};
    vecs[2]  = '{1'b0, mk(0, 0, 1, 1, 0, 0, 0)};
    vecs[3]  = '{1'b1, mk(0, 0, 1, 2, 0, 0, 0)};
    vecs[4]  = '{1'b1, mk(0, 0, 1, 3, 0, 0, 0)};
    vecs[5]  = '{1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[6]  = '{1'b1, mk(1, 0, 0, 0, 0, 0, 0)};
    vecs[7]  = '{1'b1, mk(1, 0, 0, 0, 0, 0, 0)};
    vecs[8]  = '{1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{1'b1, mk(0, 0, 1, 0, 1, 1, 0)};
    vecs[10] = '{1'b0, mk(0, 0, 1, 0, 1, 0, 0)};
    vecs[11] = '{1'b1, mk(0, 0, 1, 1, 1, 0, 0)};

    // Reset values, then the first tick after release shows pixel (0,0).
    rst_n  = 1'b0;
    pix_en = 1'b0;
    repeat (3) tick();
    check("rst_idle_def", d_obs, mk(1, 1, 0, 0, 0, 0, 0));
    check("rst_idle_small", s_obs, mk(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick();
    check("release_no_en_def", d_obs, mk(1, 1, 0, 0, 0, 0, 0));
    pix_en = 1'b1;
    tick();
    check("first_tick_def", d_obs, mk(1, 1, 1, 0, 0, 1, 1));
    check("first_tick_small", s_obs, mk(0, 0, 1, 0, 0, 1, 1));

    // Two full default lines at pix_en=1.
    act_cnt = 0; xerr = 0; hs_low = 0; hs_first = -1; ls_cnt = 0; fs_cnt = 0;
    vs_low = 0; ls_prev_p = -1; ls_period = 0;
    for (int p = 0; p < 1600; p++) begin
      if (p > 0) tick();
      if (p < 800) begin
        if (d_act) act_cnt++;
        if (d_act ? (d_x != 10'(p)) : (d_x != 10'd0)) xerr++;
        if (!d_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = p;
        end
      end
      if (!d_vs) vs_low++;
      if (d_fs) fs_cnt++;
      if (d_ls) begin
        ls_cnt++;
        if (ls_prev_p >= 0 && ls_period == 0) ls_period = p - ls_prev_p;
        ls_prev_p = p;
      end
    end
    check_int("line_active_ticks", act_cnt, 640);
    check_int("line_pix_x_errors", xerr, 0);
    check_int("line_hsync_low_ticks", hs_low, 96);
    check_int("line_hsync_start", hs_first, 656);
    check_int("line_start_period", ls_period, 800);
    check_int("line_start_count", ls_cnt, 2);
    check_int("frame_start_count", fs_cnt, 1);
    check_int("vsync_low_lines01", vs_low, 0);

    // Async reset mid-line at pixel (300,2), between clock edges.
    repeat (300) tick();
    check("pre_reset_pixel", d_obs, mk(1, 1, 1, 299, 2, 0, 0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_def", d_obs, mk(1, 1, 0, 0, 0, 0, 0));
    check("async_rst_small", s_obs, mk(0, 0, 0, 0, 0, 0, 0));
    tick();
    pix_en = 1'b0;
    rst_n  = 1'b1;
    tick();
    check("post_rst_hold_def", d_obs, mk(1, 1, 0, 0, 0, 0, 0));

    // Table: small raster from (0,0), with pix_en gaps.
    for (int i = 0; i < 12; i++) begin
      pix_en = vecs[i].en;
      tick();
      check($sformatf("vec%0d", i), s_obs, vecs[i].exp);
      if (i == 0) check("restart_def", d_obs, mk(1, 1, 1, 0, 0, 1, 1));
    end

    // Small raster against the reference over three frames; counters now hold (2,1).
    pix_en = 1'b1;
    mh = 2; mv = 1;
    fs_seen = 0; fs_t0 = 0; fs_per = 0; win_vs = 0; win_act = 0; win_hs = 0;
    for (int t = 0; t < 144; t++) begin
      tick();
      check($sformatf("model_t%0d", t), s_obs, small_ref(mh, mv));
      if (s_fs) begin
        fs_seen++;
        if (fs_seen == 1) fs_t0 = t;
        if (fs_seen == 2) fs_per = t - fs_t0;
      end
      if (fs_seen == 1) begin
        if (s_vs) win_vs++;
        if (s_act) win_act++;
        if (s_hs) win_hs++;
      end
      if (mh == 7) begin
        mh = 0;
        mv = (mv == 5) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    check_int("small_frame_period", fs_per, 48);
    check_int("small_vsync_ticks", win_vs, 8);
    check_int("small_active_ticks", win_act, 12);
    check_int("small_hsync_ticks", win_hs, 12);

    // Default raster with pix_en on every 2nd clk.
    hold_err = 0; width_err = 0; per_err = 0; per_first = 0; ls_last_c = -1;
    hs_run = 0; hs_run_first = 0; hs_seen_high = 1'b0;
    prev = d_obs;
    for (int c = 0; c < 6000; c++) begin
      pix_en = (c % 2 == 0);
      tick();
      if (!pix_en) begin
        if ({d_hs, d_vs, d_act, d_x, d_y} !== {prev.hs, prev.vs, prev.act, prev.x, prev.y}) hold_err++;
        if (d_ls || d_fs) width_err++;
      end
      if (d_ls) begin
        if (ls_last_c >= 0) begin
          if (per_first == 0) per_first = c - ls_last_c;
          else if (c - ls_last_c != 1600) per_err++;
        end
        ls_last_c = c;
      end
      if (d_hs) begin
        if (hs_seen_high && hs_run > 0 && hs_run_first == 0) hs_run_first = hs_run;
        hs_seen_high = 1'b1;
        hs_run = 0;
      end else if (hs_seen_high) begin
        hs_run++;
      end
      prev = d_obs;
    end
    check_int("half_rate_line_period", per_first, 1600);
    check_int("half_rate_period_errors", per_err, 0);
    check_int("half_rate_strobe_width_errors", width_err, 0);
    check_int("half_rate_hold_errors", hold_err, 0);
    check_int("half_rate_hsync_low_clks", hs_run_first, 192);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
